// File: rtl/params_bram_loader.sv
// Parameter BRAM loader: packs SIZE incoming BIT_WIDTH-bit words per line and
// writes DEPTH lines to the parameter store at addresses 0..DEPTH-1, then
// raises done so the reader side can start its sweep.
module params_bram_loader #(
  parameter int BIT_WIDTH  = 8,
  parameter int SIZE       = 26,
  parameter int DEPTH      = 26,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int IDX_WIDTH  = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter int DATA_WIDTH = BIT_WIDTH * SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [BIT_WIDTH-1:0]  in_data_i,
  output logic                  in_ready_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state_q,     state_d;
  logic [IDX_WIDTH-1:0]  word_idx_q,  word_idx_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [DATA_WIDTH-1:0] pack_q,      pack_d;
  logic [DATA_WIDTH-1:0] ram_data_q,  ram_data_d;

  // Next-state logic: sequencing of fill / write / done and word packing.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    line_addr_d = line_addr_q;
    pack_d      = pack_q;
    ram_data_d  = ram_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_FILL;
          word_idx_d  = '0;
          line_addr_d = '0;
          pack_d      = '0;
        end
      end

      S_FILL: begin
        if (in_valid_i) begin
          // Word k lands in slot k, word 0 in the least significant bits.
          pack_d[word_idx_q*BIT_WIDTH +: BIT_WIDTH] = in_data_i;
          if (word_idx_q == LAST_IDX) begin
            word_idx_d = '0;
            // Freeze the completed line for the write cycle and beyond.
            ram_data_d = pack_d;
            state_d    = S_WRITE;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        if (line_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          line_addr_d = line_addr_q + 1'b1;
          state_d     = S_FILL;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      line_addr_q <= '0;
      pack_q      <= '0;
      ram_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      line_addr_q <= line_addr_d;
      pack_q      <= pack_d;
      ram_data_q  <= ram_data_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output directly.
  always_comb begin
    in_ready_o = (state_q == S_FILL);
    ram_we_o   = (state_q == S_WRITE);
    busy_o     = (state_q == S_FILL) || (state_q == S_WRITE);
    done_o     = (state_q == S_DONE);
    ram_addr_o = line_addr_q;
    ram_data_o = ram_data_q;
  end

endmodule

// File: tb/tb_params_bram_loader.sv
// Self-checking bench for params_bram_loader (BIT_WIDTH=8, SIZE=4, DEPTH=2).
// A transaction-level model tracks accepted words and expected handshake /
// write timing; a single compare process checks the DUT on every cycle.
module tb_params_bram_loader;

  localparam int BW = 8;
  localparam int SZ = 4;
  localparam int DP = 2;
  localparam int AW = 1;
  localparam int DW = BW * SZ;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_data;
  logic          busy;
  logic          done;

  params_bram_loader #(
    .BIT_WIDTH(BW),
    .SIZE     (SZ),
    .DEPTH    (DP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .in_valid_i(in_valid),
    .in_data_i (in_data),
    .in_ready_o(in_ready),
    .ram_addr_o(ram_addr),
    .ram_we_o  (ram_we),
    .ram_data_o(ram_data),
    .busy_o    (busy),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: a load is in progress; m_we: this cycle is a line write;
  // m_cnt: words gathered for the current line; m_line: line being built.
  logic     m_busy, m_done, m_we;
  int       m_cnt, m_line;
  logic [BW-1:0] wq[$];   // accepted words not yet written out

  wire m_rdy = m_busy && !m_we;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_we   <= 1'b0;
      m_cnt  <= 0;
      m_line <= 0;
      wq.delete();
    end else if (m_we) begin
      m_we <= 1'b0;
      if (m_line == DP - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_line <= m_line + 1;
      end
    end else if (m_busy) begin
      if (in_valid) begin
        wq.push_back(in_data);
        if (m_cnt == SZ - 1) begin
          m_cnt <= 0;
          m_we  <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_line <= 0;
      m_cnt  <= 0;
    end
  end

  // ---------------- observation / compare ----------------
  int            cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [DP];
  int            we_count = 0;
  int            wcyc [DP];
  int            done_rise_cyc = 0;
  logic          prev_done = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", in_ready, m_rdy);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("ram_we", ram_we, m_we);
      if (m_we) begin
        logic [DW-1:0] exp_line;
        exp_line = '0;
        if (wq.size() < SZ) begin
          check("queue_words", wq.size(), SZ);
        end else begin
          for (int k = 0; k < SZ; k++) exp_line[k*BW +: BW] = wq.pop_front();
          check("ram_addr", ram_addr, m_line);
          check("ram_data", ram_data, exp_line);
        end
      end
      if (ram_we) begin
        mem[ram_addr]  = ram_data;
        wcyc[ram_addr] = cyc;
        we_count++;
      end
      if (done && !prev_done) done_rise_cyc = cyc;
      prev_done = done;
    end
  end

  // ---------------- stimulus helpers (all entered at a negedge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [BW-1:0] w, input int gaps);
    logic ok;
    ok = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 100; i++) begin
      if (m_rdy) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("send_accepted", ok, 1'b1);
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_reached", ok, 1'b1);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < DP; a++) mem[a] = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Full load, continuous stream.
    clear_mem();
    pulse_start();
    for (int i = 1; i <= 8; i++) send(BW'(i), 0);
    wait_done();
    check("full_mem0", mem[0], 32'h04030201);
    check("full_mem1", mem[1], 32'h08070605);
    check("full_spacing", wcyc[1] - wcyc[0], 5);
    check("full_done_lat", done_rise_cyc - wcyc[1], 1);

    // Gaps in in_valid: 1,0,0,1,...
    clear_mem();
    pulse_start();
    for (int i = 1; i <= 8; i++) send(BW'(i), (i % 2 == 0) ? 2 : 0);
    wait_done();
    check("gap_mem0", mem[0], 32'h04030201);
    check("gap_mem1", mem[1], 32'h08070605);

    // Start asserted mid-fill is ignored.
    clear_mem();
    pulse_start();
    send(8'h01, 0);
    send(8'h02, 0);
    pulse_start();
    for (int i = 3; i <= 8; i++) send(BW'(i), 0);
    wait_done();
    check("ign_mem0", mem[0], 32'h04030201);
    check("ign_mem1", mem[1], 32'h08070605);

    // Asynchronous reset part-way through line 1.
    clear_mem();
    base = we_count;
    pulse_start();
    for (int i = 0; i < 6; i++) send(BW'(8'h50 + i), 0);
    check("rst_writes_before", we_count - base, 1);
    #3 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 1'b0);
    check("rst_ram_data", ram_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    #3 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_no_write", we_count - base, 1);
    check("rst_idle_ready", in_ready, 1'b0);
    clear_mem();
    pulse_start();
    for (int i = 0; i < 8; i++) send(BW'(8'hA0 + i), 0);
    wait_done();
    check("rst_mem0", mem[0], 32'hA3A2A1A0);
    check("rst_mem1", mem[1], 32'hA7A6A5A4);

    // Restart from DONE.
    clear_mem();
    pulse_start();
    check("restart_done_low", done, 1'b0);
    check("restart_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) send(8'hFF, 0);
    wait_done();
    check("restart_mem0", mem[0], 32'hFFFFFFFF);
    check("restart_mem1", mem[1], 32'hFFFFFFFF);

    // Randomised traffic: random valid, data and start glitches.
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = BW'($urandom);
      start    = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/params_bram_loader.md
# params_bram_loader

Write-side counterpart of the parameter ROM reader. Accepts a stream of BIT_WIDTH-bit parameter words over a valid/ready handshake, packs SIZE consecutive words into one BIT_WIDTH*SIZE-bit line, and writes each line into the `single_port_ram` parameter store at incrementing addresses 0..DEPTH-1. It sits between the host/DMA parameter stream and the weight BRAM, and signals completion so the reader side can begin its address sweep.

## Interface

- BIT_WIDTH, 8, width of one parameter word
- SIZE, 26, words packed per BRAM line; RAM data width = BIT_WIDTH*SIZE
- DEPTH, 26, number of lines written per load; address width ADDR_WIDTH = clogb2(DEPTH)

- clk  input  1  single clock; all state changes on posedge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  begin a load; sampled only in IDLE or DONE
- in_valid  input  1  in_data holds a valid word
- in_data  input  BIT_WIDTH  parameter word
- in_ready  output  1  loader accepts a word this cycle (transfer = in_valid & in_ready)
- ram_addr  output  ADDR_WIDTH  BRAM write address
- ram_we  output  1  BRAM write enable, one-cycle pulse per line
- ram_data  output  BIT_WIDTH*SIZE  packed line to BRAM
- busy  output  1  high in FILL and WRITE
- done  output  1  high in DONE; held until next start or reset

## Operation

- States: IDLE, FILL, WRITE, DONE. Reset -> IDLE.
- IDLE: in_ready=0. start=1 -> FILL; line_addr<=0, word_idx<=0, packing register cleared to 0.
- FILL: in_ready=1. Each transfer writes in_data into slot word_idx, slot k occupying bits [k*BIT_WIDTH +: BIT_WIDTH] (word 0 in LSBs); word_idx increments. Transfer with word_idx==SIZE-1 -> WRITE, word_idx<=0.
- WRITE (one cycle): ram_we=1, ram_addr=line_addr, ram_data=packed line; in_ready=0. Then line_addr==DEPTH-1 -> DONE, else line_addr<=line_addr+1 and -> FILL.
- DONE: done=1, in_ready=0, ram_we=0. start=1 -> FILL with same initialisation as IDLE.
- start in FILL or WRITE is ignored; no effect on counters.
- in_valid in IDLE/WRITE/DONE is not accepted (in_ready=0); upstream holds the word.
- word_idx counts 0..SIZE-1, line_addr 0..DEPTH-1; neither wraps past its limit; counters sized clogb2(SIZE) and clogb2(DEPTH).
- ram_data holds the last packed line between writes; value is only meaningful when ram_we=1.

## Timing

- All outputs are registered or decoded from registered state; no combinational path from in_valid/start to any output.
- Reset values: in_ready=0, ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0; state IDLE; counters 0.
- Reset asserted mid-load: outputs take reset values immediately (asynchronous); partially filled line is discarded, no write issued; after release block waits in IDLE for start.
- start sampled at edge t -> in_ready=1 from cycle t+1.
- Final word of a line accepted at edge t -> ram_we=1 during cycle t+1 with correct ram_addr/ram_data; in_ready=0 during t+1; in_ready=1 again from t+2 (if more lines).
- Throughput with in_valid held high: SIZE+1 cycles per line; full load DEPTH*(SIZE+1) cycles after start.
- Last write pulse in cycle T -> done=1 and busy=0 from cycle T+1.
- Stalls (in_valid=0) in FILL freeze word_idx and packing register indefinitely.

## Test plan

- Reset: assert rst asynchronously between edges with BIT_WIDTH=8, SIZE=4, DEPTH=2 -> all outputs 0 immediately; state IDLE, in_ready=0 after release.
- Full load, no gaps: start, stream 0x01..0x08 continuously -> ram_we pulses at addr 0 with ram_data=0x04030201 and addr 1 with 0x08070605, exactly 5 cycles apart; done=1 the cycle after second pulse.
- Backpressure/gaps: same stream with in_valid toggled 1,0,0,1,... -> identical RAM contents; words held while in_valid=0 not duplicated; in_ready=0 during each WRITE cycle.
- Ignored start: pulse start after 2 words in FILL -> word_idx and line_addr unchanged; same final contents as no-glitch run.
- Reset mid-fill: assert rst after 6 words -> no ram_we for line 1; after release and new start with 0xA0..0xA7 -> addr 0 gets 0xA3A2A1A0, addr 1 gets 0xA7A6A5A4.
- Restart from DONE: after done=1, pulse start and stream 0xFF x8 -> done drops next cycle, both lines written as 0xFFFFFFFF, done reasserts.
